// File: rtl/xbar_rr_ctrl_gen.sv
// Round-robin control-word generator feeding an N-to-1 crossbar output stage.
// Grants one requesting input, issues its control word, then holds for PKT_LEN beats.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req_val      : per-input valid (crossbar recv_val)
//   xfer_fire    : crossbar output handshake (send_val && send_rdy)
//   control      : control word, grant index in the top bits
//   control_val  : control word valid (ISSUE state)
//   control_rdy  : crossbar accepts control word
//   grant_idx    : currently granted input
//   busy         : high in ISSUE and HOLD
module xbar_rr_ctrl_gen #(
  parameter int N_INPUTS          = 2,
  parameter int CONTROL_BIT_WIDTH = 32,
  parameter int PKT_LEN           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS-1:0]          req_val,
  input  logic                         xfer_fire,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  output logic [$clog2(N_INPUTS)-1:0]  grant_idx,
  output logic                         busy
);

  localparam int IW   = $clog2(N_INPUTS);
  localparam int CW   = CONTROL_BIT_WIDTH;
  localparam int CNTW = $clog2(PKT_LEN+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [CNTW-1:0] cnt;
  logic [IW-1:0]   sel;

  // Modulo-N add; N need not be a power of two.
  function automatic logic [IW-1:0] add_wrap(
    input logic [IW-1:0] a,
    input int            b
  );
    int s;
    s = int'(a) + b;
    if (s >= N_INPUTS)
      s = s - N_INPUTS;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the
  // closest requester at or above ptr wins.
  always_comb begin
    sel = '0;
    for (int i = N_INPUTS-1; i >= 0; i--) begin
      if (req_val[add_wrap(ptr, i)])
        sel = add_wrap(ptr, i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      control   <= '0;
      grant_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_val) begin
            grant_idx <= sel;
            control   <= {sel, {(CW-IW){1'b0}}};
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (control_rdy) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (xfer_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNTW'(PKT_LEN-1)) begin
              state <= IDLE;
              ptr   <= add_wrap(grant_idx, 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign control_val = (state == ISSUE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_xbar_rr_ctrl_gen.sv
// Bench for xbar_rr_ctrl_gen: two instances (N=2/PKT=4, N=3/PKT=1)
// checked every cycle against a transaction-level reference model.
module tb_xbar_rr_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_a;
  logic        rdy_a, fire_a;
  logic [2:0]  req_b;
  logic        rdy_b, fire_b;

  logic [31:0] ctl_a, ctl_b;
  logic        val_a, val_b, busy_a, busy_b;
  logic        gnt_a;
  logic [1:0]  gnt_b;

  always #5 clk = ~clk;

  xbar_rr_ctrl_gen #(
    .N_INPUTS(2), .CONTROL_BIT_WIDTH(32), .PKT_LEN(4)
  ) u_a (
    .clk(clk), .reset(reset), .req_val(req_a),
    .xfer_fire(fire_a), .control(ctl_a),
    .control_val(val_a), .control_rdy(rdy_a),
    .grant_idx(gnt_a), .busy(busy_a)
  );

  xbar_rr_ctrl_gen #(
    .N_INPUTS(3), .CONTROL_BIT_WIDTH(32), .PKT_LEN(1)
  ) u_b (
    .clk(clk), .reset(reset), .req_val(req_b),
    .xfer_fire(fire_b), .control(ctl_b),
    .control_val(val_b), .control_rdy(rdy_b),
    .grant_idx(gnt_b), .busy(busy_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit armed  = 1'b0;

  // Reference: phase 0 = no grant, 1 = word offered,
  // 2 = packet in flight with beats counted up to L.
  int NN[2] = '{2, 3};
  int LL[2] = '{4, 1};
  int IWd[2] = '{1, 2};
  int ph[2], ptr[2], gnt[2], beats[2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic void mstep(int k, bit rst, int req, bit rdy, bit fire);
    if (rst) begin
      ph[k] = 0; ptr[k] = 0; gnt[k] = 0; beats[k] = 0;
      return;
    end
    case (ph[k])
      0: if (req != 0) begin
        for (int o = NN[k]-1; o >= 0; o--)
          if (((req >> ((ptr[k]+o) % NN[k])) & 1) != 0)
            gnt[k] = (ptr[k]+o) % NN[k];
        ph[k] = 1;
      end
      1: if (rdy) begin ph[k] = 2; beats[k] = 0; end
      default: if (fire) begin
        beats[k]++;
        if (beats[k] == LL[k]) begin
          ph[k] = 0;
          ptr[k] = (gnt[k] + 1) % NN[k];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] exp_ctl(int k);
    logic [31:0] w;
    w = 32'(gnt[k]);
    return w << (32 - IWd[k]);
  endfunction

  task automatic cyc(input bit rst,
                     input logic [1:0] ra, input bit rda, input bit fa,
                     input logic [2:0] rb, input bit rdb, input bit fb);
    @(negedge clk);
    if (armed) begin
      check("a.val",  32'(val_a),  32'(ph[0] == 1));
      check("a.busy", 32'(busy_a), 32'(ph[0] != 0));
      check("a.gnt",  32'(gnt_a),  32'(gnt[0]));
      check("a.ctl",  ctl_a,       exp_ctl(0));
      check("b.val",  32'(val_b),  32'(ph[1] == 1));
      check("b.busy", 32'(busy_b), 32'(ph[1] != 0));
      check("b.gnt",  32'(gnt_b),  32'(gnt[1]));
      check("b.ctl",  ctl_b,       exp_ctl(1));
    end
    reset = rst;
    req_a = ra; rdy_a = rda; fire_a = fa;
    req_b = rb; rdy_b = rdb; fire_b = fb;
    mstep(0, rst, int'(ra), rda, fa);
    mstep(1, rst, int'(rb), rdb, fb);
    if (rst) armed = 1'b1;
  endtask

  int rb_seq[4] = '{1, 2, 4, 2};

  initial begin
    reset = 1'b1;
    req_a = '0; rdy_a = 1'b0; fire_a = 1'b0;
    req_b = '0; rdy_b = 1'b0; fire_b = 1'b0;
    repeat (2) cyc(1, 2'b00, 0, 0, 3'b000, 0, 0);

    // Single request on input 1, then 4 beats back to IDLE.
    cyc(0, 2'b10, 1, 0, 3'b000, 0, 0);
    cyc(0, 2'b00, 1, 0, 3'b000, 0, 0);
    repeat (4) cyc(0, 2'b00, 0, 1, 3'b000, 0, 0);
    repeat (2) cyc(0, 2'b00, 0, 0, 3'b000, 0, 0);

    // Both inputs requesting, fire every cycle: alternating grants.
    repeat (26) cyc(0, 2'b11, 1, 1, 3'b000, 0, 0);
    repeat (3) cyc(0, 2'b00, 1, 1, 3'b000, 0, 0);

    // Stall in ISSUE with fire pulses that must be ignored.
    cyc(0, 2'b01, 0, 1, 3'b000, 0, 0);
    repeat (5) cyc(0, 2'b11, 0, 1, 3'b000, 0, 0);
    cyc(0, 2'b00, 1, 0, 3'b000, 0, 0);

    // Reset after 2 beats of HOLD, then new grant from ptr 0.
    repeat (2) cyc(0, 2'b00, 0, 1, 3'b000, 0, 0);
    cyc(1, 2'b00, 0, 0, 3'b000, 0, 0);
    repeat (3) cyc(0, 2'b11, 1, 0, 3'b000, 0, 0);
    repeat (6) cyc(0, 2'b00, 1, 1, 3'b000, 0, 0);

    // N=3, PKT=1: walk ptr to 2, grant 2, wrap, then grant 1.
    // Fire gaps hold the grant until the single beat lands.
    foreach (rb_seq[i]) begin
      cyc(0, 2'b00, 0, 0, 3'(rb_seq[i]), 0, 1);
      cyc(0, 2'b00, 0, 0, 3'b000, 1, 1);
      repeat (2) cyc(0, 2'b00, 0, 0, 3'b111, 0, 0);
      cyc(0, 2'b00, 0, 0, 3'b000, 0, 1);
      cyc(0, 2'b00, 0, 0, 3'b000, 0, 0);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 249) == 0,
          2'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0,
          3'($urandom_range(0, 7)),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0);
    end
    cyc(0, 2'b00, 0, 0, 3'b000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
